// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC / redirect controller.
// Pure definitions: no latency, no flow control.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter; increments by one per cycle with inc high, sticks at all-ones.
// Count visible the cycle after inc; no backpressure.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/fetch_redirect.sv
// Fetch PC sequencer: loads the taken-branch target, holds flush for FLUSH_DEPTH cycles, then resumes pc+4.
// Redirect visible one cycle after take; stall freezes pc in RUN only, flush overrides stall.
module fetch_redirect
    import fetch_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DEFAULT),
    parameter int               FLUSH_DEPTH = 2,
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 take,
    input  logic [WIDTH-1:0]     target,
    output logic [WIDTH-1:0]     pc,
    output logic                 fetch_valid,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);

    localparam int FW = $clog2(FLUSH_DEPTH + 1);

    state_t        state;
    logic [FW-1:0] flush_cnt;
    logic          redirect;

    // A take seen while flushing belongs to a squashed instruction, so only RUN accepts it.
    assign redirect    = (state == RUN) && take;
    assign fetch_valid = (state == RUN) && !stall && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            flush     <= 1'b0;
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (take) begin
                        pc        <= target;
                        flush     <= 1'b1;
                        flush_cnt <= FW'(FLUSH_DEPTH - 1);
                        state     <= FLUSH;
                    end else if (stall) begin
                        flush <= 1'b0;
                    end else begin
                        pc    <= pc + WIDTH'(PC_INC);
                        flush <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_redirect_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (redirect),
        .count(redirect_cnt)
    );

endmodule : fetch_redirect

// File: doc/fetch_redirect.md
# fetch_redirect

Program-counter and redirect controller for the fetch end of the pipeline. It consumes the taken-branch decision (`take`, `target`) produced in EX by the branch judge. On a taken branch or jump it loads the target PC, squashes the wrong-path slots with a timed flush, and then resumes sequential fetch. It also keeps a saturating count of accepted redirects for the MyHDL co-simulation scoreboard.

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `FLUSH_DEPTH`, 2: number of cycles flush is held after a redirect (1..15).
- `CNT_WIDTH`, 16: width of the redirect counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard-unit freeze. Holds the PC while in RUN.
- `take`  in  1  branch/jump taken, from branch_judge `out`.
- `target`  in  WIDTH  redirect PC. Valid when `take`=1.
- `pc`  out  WIDTH  current fetch address (registered).
- `fetch_valid`  out  1  the instruction fetched at `pc` this cycle is on the correct path.
- `flush`  out  1  kill IF/ID and ID/EX contents (registered).
- `redirect_cnt`  out  CNT_WIDTH  number of accepted redirects, saturating.

## Operation
States:
- RUN: sequential fetch.
- FLUSH: squash window.

RUN, at each rising edge, in priority order:
- `take`=1: `pc`<=`target`; `flush`<=1; `flush_cnt`<=FLUSH_DEPTH-1; go to FLUSH; `redirect_cnt`++. `take` wins over `stall`.
- else `stall`=1: `pc` holds; `flush`<=0.
- else: `pc`<=`pc`+4 (wraps modulo 2^WIDTH); `flush`<=0.

FLUSH, at each rising edge:
- `pc` holds `target`.
- `take` is ignored: it comes from a squashed wrong-path instruction. It is not counted.
- `stall` is ignored: flush overrides the freeze.
- `flush_cnt`==0: `flush`<=0; go to RUN.
- else: `flush_cnt`--; `flush` stays 1.

Outputs:
- `fetch_valid` = (state==RUN) & ~`stall` & ~`reset`. It is combinational.
- `redirect_cnt` saturates at all-ones and never wraps.
- PC arithmetic is unsigned WIDTH-bit. `target` is used verbatim; alignment is not checked.

## Timing
- Reset (asynchronous, effective immediately, including mid-FLUSH):
  - `pc`=RESET_PC, `flush`=0, `redirect_cnt`=0, state=RUN, `flush_cnt`=0.
  - `fetch_valid`=0 while `reset` is high.
- First sequential advance: on the first edge after `reset` falls, `pc` becomes RESET_PC+4.
- Redirect latency: `take` is sampled high at edge N.
  - `pc`=`target` and `flush`=1 from N+1.
  - `flush` is high for exactly FLUSH_DEPTH cycles, N+1 .. N+FLUSH_DEPTH.
  - `fetch_valid`=0 over the same cycles.
  - The first valid fetch of `target` is at cycle N+FLUSH_DEPTH+1. `pc` advances to `target`+4 at the following edge unless stalled.
- `redirect_cnt` updates in the same cycle `pc` becomes `target`.
- Back-to-back redirects: a `take` on the edge that exits FLUSH is ignored. The earliest re-redirect is sampled in the first RUN cycle.

## Structure
- Package `fetch_pkg`:
  - state enum {RUN, FLUSH}
  - `PC_INC`=4
  - default `RESET_PC`
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `reset`, `inc`, `count`) for `redirect_cnt`. It is also reusable for stall statistics.
- The flush down-counter and the state register are inline, at $clog2(FLUSH_DEPTH+1) bits.

## Test plan
- Reset then free-run, no stall: `pc` = 0, 4, 8, 12 on successive cycles; `fetch_valid`=1; `flush`=0.
- `stall`=1 for 3 cycles at `pc`=8: `pc` holds 8 and `fetch_valid`=0 for those 3 cycles, then continues at 12.
- `take`=1, `target`=0x100 at edge N with FLUSH_DEPTH=2:
  - `pc`=0x100 at N+1.
  - `flush`=1 at N+1 and N+2, with `fetch_valid`=0.
  - `fetch_valid`=1 at N+3; `pc`=0x104 at N+4.
  - `redirect_cnt`=1.
- `take`=1, `target`=0x200 during FLUSH, and `stall`=1 during FLUSH: both are ignored. `pc` stays 0x100; the FLUSH length is unchanged; `redirect_cnt` is unchanged.
- `take` and `stall` both high in RUN: the redirect happens (`pc`=`target`). Separately, with `pc`=0xFFFF_FFFC and no stall, `pc` wraps to 0.
- Reset asserted mid-FLUSH:
  - Immediately: `pc`=0, `flush`=0, `redirect_cnt`=0.
  - After release, normal sequential fetch.
  - With CNT_WIDTH=2, 5 redirects leave `redirect_cnt`=3.
